count_serializer: RTL

- Downstream consumer of the dual 64-bit event counter outputs (Output0 / Output1).
- On request, snapshots both counts atomically and streams them as a framed byte sequence over a valid/ready interface toward the UART/debug-display stage.
- Frame format: header byte, Count0 bytes LSB-first, Count1 bytes LSB-first, checksum byte.

---
 rtl/count_serializer_pkg.sv | 24 ++
 rtl/count_serializer_byte_mux.sv | 20 ++
 rtl/count_serializer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/count_serializer_pkg.sv
// Shared definitions for the count serializer: FSM state encoding, default frame
// header and byte-count derivation helpers.
package count_serializer_pkg;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StHdr  = 3'd1,
        StC0   = 3'd2,
        StC1   = 3'd3,
        StCsum = 3'd4
    } state_e;

    localparam logic [7:0] HeaderDefault = 8'hA5;

    function automatic int unsigned bytes_per_count(input int unsigned count_w);
        return count_w / 8;
    endfunction

    // A single-byte count still needs a 1-bit index register to keep widths legal.
    function automatic int unsigned idx_width(input int unsigned nb);
        return (nb > 1) ? $clog2(nb) : 1;
    endfunction

endpackage

// File: rtl/count_serializer_byte_mux.sv
// Combinational byte selector: returns byte idx (LSB-first) of a COUNT_W-bit vector.
module byte_mux #(
    parameter int unsigned COUNT_W = 64,
    parameter int unsigned IDX_W   = 3
) (
    input  logic [COUNT_W-1:0] vec,
    input  logic [IDX_W-1:0]   idx,
    output logic [7:0]         sel_byte
);

    always_comb begin
        sel_byte = 8'h00;
        for (int i = 0; i < int'(COUNT_W / 8); i++) begin
            if (idx == IDX_W'(i)) begin
                sel_byte = vec[i*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/count_serializer.sv
// Snapshots two event counts on request and streams them as a framed byte sequence:
// header, Count0 LSB-first, Count1 LSB-first, 8-bit additive checksum of the payload.
module count_serializer
    import count_serializer_pkg::*;
#(
    parameter int unsigned COUNT_W = 64,
    parameter logic [7:0]  HEADER  = HeaderDefault
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [COUNT_W-1:0] Count0,
    input  logic [COUNT_W-1:0] Count1,
    input  logic               Req,
    output logic [7:0]         Data,
    output logic               Valid,
    input  logic               Ready,
    output logic               Busy,
    output logic               Done
);

    localparam int unsigned NB   = bytes_per_count(COUNT_W);
    localparam int unsigned IdxW = idx_width(NB);

    state_e             state;
    logic [IdxW-1:0]    idx;
    logic [7:0]         csum;
    logic [COUNT_W-1:0] snap0;
    logic [COUNT_W-1:0] snap1;

    logic [COUNT_W-1:0] mux_vec;
    logic [7:0]         cur_byte;
    logic               accept;
    logic               last_byte;

    assign mux_vec   = (state == StC1) ? snap1 : snap0;
    assign accept    = Valid & Ready;
    assign last_byte = (idx == IdxW'(NB - 1));

    byte_mux #(
        .COUNT_W (COUNT_W),
        .IDX_W   (IdxW)
    ) u_byte_mux (
        .vec      (mux_vec),
        .idx      (idx),
        .sel_byte (cur_byte)
    );

    // Data is decoded from registered state only, so it holds steady under backpressure.
    always_comb begin
        Data = 8'h00;
        case (state)
            StHdr:       Data = HEADER;
            StC0, StC1:  Data = cur_byte;
            StCsum:      Data = csum;
            default:     Data = 8'h00;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= StIdle;
            idx   <= '0;
            csum  <= 8'h00;
            snap0 <= '0;
            snap1 <= '0;
            Valid <= 1'b0;
            Busy  <= 1'b0;
            Done  <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                StIdle: begin
                    if (Req) begin
                        snap0 <= Count0;
                        snap1 <= Count1;
                        csum  <= 8'h00;
                        idx   <= '0;
                        state <= StHdr;
                        Valid <= 1'b1;
                        Busy  <= 1'b1;
                    end
                end
                StHdr: begin
                    if (accept) begin
                        state <= StC0;
                        idx   <= '0;
                    end
                end
                StC0: begin
                    if (accept) begin
                        csum <= csum + cur_byte;
                        if (last_byte) begin
                            state <= StC1;
                            idx   <= '0;
                        end else begin
                            idx <= idx + IdxW'(1);
                        end
                    end
                end
                StC1: begin
                    if (accept) begin
                        csum <= csum + cur_byte;
                        if (last_byte) begin
                            state <= StCsum;
                            idx   <= '0;
                        end else begin
                            idx <= idx + IdxW'(1);
                        end
                    end
                end
                StCsum: begin
                    if (accept) begin
                        state <= StIdle;
                        Valid <= 1'b0;
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                    end
                end
                default: begin
                    state <= StIdle;
                    Valid <= 1'b0;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
